// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Pixel-rate timing generator for the 640x480@60 text display.
//   Produces the character-lookup position (vga_hpos/vga_vpos, undelayed) and
//   the sync/blank strobes, which are delayed PIPE_DELAY cycles so they line up
//   with the glyph pixel the text renderer emits downstream.
//
//   Optional feature macro: VGA_FRAME_COUNT_EN
//     defined   -> frame_count is a free-running 8-bit frame counter
//                  (the first frame_start after reset does not count).
//     undefined -> frame_count is tied to zero, no counter register exists.
//
// Ports
//   pixel_clock  in   1   pixel clock
//   reset        in   1   synchronous, active-high
//   vga_hpos     out  11  horizontal position 0..H_TOTAL-1
//   vga_vpos     out  10  vertical position 0..V_TOTAL-1
//   line_start   out  1   high while vga_hpos == 0
//   frame_start  out  1   high while vga_hpos == 0 && vga_vpos == 0
//   h_sync       out  1   active-low horizontal sync, delayed PIPE_DELAY cycles
//   v_sync       out  1   active-low vertical sync, delayed PIPE_DELAY cycles
//   blank_n      out  1   high in the visible area, delayed PIPE_DELAY cycles
//   frame_count  out  8   frame counter (see VGA_FRAME_COUNT_EN)
// -----------------------------------------------------------------------------
module vga_sync_gen #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned PIPE_DELAY = 2
) (
   input  logic        pixel_clock,
   input  logic        reset,
   output logic [10:0] vga_hpos,
   output logic [9:0]  vga_vpos,
   output logic        line_start,
   output logic        frame_start,
   output logic        h_sync,
   output logic        v_sync,
   output logic        blank_n,
   output logic [7:0]  frame_count
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);

   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0]  VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   typedef struct packed {
      logic hs;
      logic vs;
      logic vis;
   } sync_t;

   // Value every delay stage holds after reset: syncs deasserted, blanked.
   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

   generate
      if (PIPE_DELAY > 7) begin : g_bad_delay
         $error("vga_sync_gen: PIPE_DELAY must be in 0..7");
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Position counters
   // --------------------------------------------------------------------------
   logic [10:0] hpos;
   logic [9:0]  vpos;

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         hpos <= '0;
         vpos <= '0;
      end else if (hpos == H_LAST) begin
         hpos <= '0;
         vpos <= (vpos == V_LAST) ? '0 : vpos + 10'd1;
      end else begin
         hpos <= hpos + 11'd1;
      end
   end

   always_comb begin
      vga_hpos    = hpos;
      vga_vpos    = vpos;
      line_start  = (hpos == '0);
      frame_start = (hpos == '0) && (vpos == '0);
   end

   // --------------------------------------------------------------------------
   // Stage-0 decode from the current counters
   // --------------------------------------------------------------------------
   sync_t raw;

   always_comb begin
      raw     = SYNC_IDLE;
      raw.hs  = !((hpos >= HS_FIRST) && (hpos <= HS_LAST));
      raw.vs  = !((vpos >= VS_FIRST) && (vpos <= VS_LAST));
      raw.vis = (hpos < H_VIS_END) && (vpos < V_VIS_END);
   end

   // --------------------------------------------------------------------------
   // Delay line: outputs are the stage-0 values from PIPE_DELAY cycles ago.
   // Reset flushes every stage to idle so no partial pulse survives a reset.
   // --------------------------------------------------------------------------
   generate
      if (PIPE_DELAY == 0) begin : g_no_delay
         always_comb begin
            h_sync  = raw.hs;
            v_sync  = raw.vs;
            blank_n = raw.vis;
         end
      end else begin : g_delay
         sync_t stage [PIPE_DELAY];

         always_ff @(posedge pixel_clock) begin
            if (reset) begin
               for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
                  stage[i] <= SYNC_IDLE;
               end
            end else begin
               stage[0] <= raw;
               for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         always_comb begin
            h_sync  = stage[PIPE_DELAY-1].hs;
            v_sync  = stage[PIPE_DELAY-1].vs;
            blank_n = stage[PIPE_DELAY-1].vis;
         end
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Frame counter
   // --------------------------------------------------------------------------
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] count;
   logic       first_seen;  // set once the post-reset frame_start has passed

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         count      <= '0;
         first_seen <= 1'b0;
      end else if (frame_start) begin
         if (first_seen) begin
            count <= count + 8'd1;
         end
         first_seen <= 1'b1;
      end
   end

   always_comb begin
      frame_count = count;
   end
`else
   assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

   // Small geometry so whole frames and counter wrap fit in a short run.
   localparam int unsigned S_HV = 10, S_HF = 2, S_HS = 3, S_HB = 2;
   localparam int unsigned S_VV = 6,  S_VF = 1, S_VS = 2, S_VB = 1;
   localparam int unsigned S_D  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;

   typedef struct packed {
      logic [10:0] h;
      logic [9:0]  v;
      logic        ls;
      logic        fs;
      logic        hs;
      logic        vs;
      logic        bl;
      logic [7:0]  fc;
   } obs_t;

   // ---------------- DUT instances ----------------
   logic [10:0] f2_h, f0_h, s_h;
   logic [9:0]  f2_v, f0_v, s_v;
   logic        f2_ls, f2_fs, f2_hs, f2_vs, f2_bl;
   logic        f0_ls, f0_fs, f0_hs, f0_vs, f0_bl;
   logic        s_ls, s_fs, s_hs, s_vs, s_bl;
   logic [7:0]  f2_fc, f0_fc, s_fc;

   vga_sync_gen #(.PIPE_DELAY(2)) dut_f2 (
      .pixel_clock(clk), .reset(reset), .vga_hpos(f2_h), .vga_vpos(f2_v),
      .line_start(f2_ls), .frame_start(f2_fs), .h_sync(f2_hs), .v_sync(f2_vs),
      .blank_n(f2_bl), .frame_count(f2_fc));

   vga_sync_gen #(.PIPE_DELAY(0)) dut_f0 (
      .pixel_clock(clk), .reset(reset), .vga_hpos(f0_h), .vga_vpos(f0_v),
      .line_start(f0_ls), .frame_start(f0_fs), .h_sync(f0_hs), .v_sync(f0_vs),
      .blank_n(f0_bl), .frame_count(f0_fc));

   vga_sync_gen #(
      .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
      .PIPE_DELAY(S_D)
   ) dut_s (
      .pixel_clock(clk), .reset(reset), .vga_hpos(s_h), .vga_vpos(s_v),
      .line_start(s_ls), .frame_start(s_fs), .h_sync(s_hs), .v_sync(s_vs),
      .blank_n(s_bl), .frame_count(s_fc));

   obs_t f2_act, f0_act, s_act;
   assign f2_act = {f2_h, f2_v, f2_ls, f2_fs, f2_hs, f2_vs, f2_bl, f2_fc};
   assign f0_act = {f0_h, f0_v, f0_ls, f0_fs, f0_hs, f0_vs, f0_bl, f0_fc};
   assign s_act  = {s_h,  s_v,  s_ls,  s_fs,  s_hs,  s_vs,  s_bl,  s_fc};

   // ---------------- reference model ----------------
   // t = cycles since the last clock edge that sampled reset high.
   longint unsigned t = 0;
   int n_cmp  = 0;
   int n_fail = 0;

   function automatic obs_t model(input int unsigned hv, hf, hsw, hb,
                                  input int unsigned vv, vf, vsw, vb,
                                  input int unsigned d, input longint unsigned tt);
      obs_t o;
      longint unsigned ht, vt, fr, hh, vl, td, hd, vd, n;
      ht = 64'(hv) + 64'(hf) + 64'(hsw) + 64'(hb);
      vt = 64'(vv) + 64'(vf) + 64'(vsw) + 64'(vb);
      fr = ht * vt;
      hh = tt % ht;
      vl = (tt / ht) % vt;
      o.h  = 11'(hh);
      o.v  = 10'(vl);
      o.ls = (hh == 0);
      o.fs = (hh == 0) && (vl == 0);
      if (tt < 64'(d)) begin
         o.hs = 1'b1; o.vs = 1'b1; o.bl = 1'b0;
      end else begin
         td = tt - 64'(d);
         hd = td % ht;
         vd = (td / ht) % vt;
         o.hs = !((hd >= 64'(hv) + 64'(hf)) && (hd < 64'(hv) + 64'(hf) + 64'(hsw)));
         o.vs = !((vd >= 64'(vv) + 64'(vf)) && (vd < 64'(vv) + 64'(vf) + 64'(vsw)));
         o.bl = (hd < 64'(hv)) && (vd < 64'(vv));
      end
      // frame_starts seen in cycles 0..tt-1; the first one does not count
      n = (tt + fr - 1) / fr;
`ifdef VGA_FRAME_COUNT_EN
      o.fc = (n == 0) ? 8'd0 : 8'((n - 1) % 256);
`else
      o.fc = (n == 0) ? 8'd0 : 8'd0;
`endif
      return o;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got h=%0d v=%0d ls/fs/hs/vs/bl=%b fc=%0d want h=%0d v=%0d ls/fs/hs/vs/bl=%b fc=%0d",
                  name, t, act.h, act.v, {act.ls, act.fs, act.hs, act.vs, act.bl}, act.fc,
                  exp.h, exp.v, {exp.ls, exp.fs, exp.hs, exp.vs, exp.bl}, exp.fc);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got %0d want %0d", name, t, act, exp);
      end
   endtask

   // One clock: advance model time, then compare every DUT against the model.
   task automatic step();
      @(posedge clk);
      if (reset) t = 0;
      else       t++;
      #1;
      check("full_d2",  f2_act, model(640, 16, 96, 48, 480, 10, 2, 33, 2, t));
      check("full_d0",  f0_act, model(640, 16, 96, 48, 480, 10, 2, 33, 0, t));
      check("small_d3", s_act,  model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_D, t));
   endtask

   // ---------------- directed vector table (full-size DUTs) ----------------
   // flags = {ls, fs, hs(d2), vs(d2), bl(d2), hs(d0), vs(d0), bl(d0)}
   typedef struct {
      int unsigned cyc;
      logic [10:0] h;
      logic [9:0]  v;
      logic [7:0]  flags;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int hs_cnt, hs_first, hs0_first, bl_cnt, vs_cnt, vs_first, fs_cnt, sbl_cnt;

      tbl.push_back('{0,   11'd0,   10'd0, 8'b11_110_111});
      tbl.push_back('{1,   11'd1,   10'd0, 8'b00_110_111});
      tbl.push_back('{2,   11'd2,   10'd0, 8'b00_111_111});
      tbl.push_back('{639, 11'd639, 10'd0, 8'b00_111_111});
      tbl.push_back('{640, 11'd640, 10'd0, 8'b00_111_110});
      tbl.push_back('{641, 11'd641, 10'd0, 8'b00_111_110});
      tbl.push_back('{642, 11'd642, 10'd0, 8'b00_110_110});
      tbl.push_back('{655, 11'd655, 10'd0, 8'b00_110_110});
      tbl.push_back('{656, 11'd656, 10'd0, 8'b00_110_010});
      tbl.push_back('{657, 11'd657, 10'd0, 8'b00_110_010});
      tbl.push_back('{658, 11'd658, 10'd0, 8'b00_010_010});
      tbl.push_back('{751, 11'd751, 10'd0, 8'b00_010_010});
      tbl.push_back('{752, 11'd752, 10'd0, 8'b00_010_110});
      tbl.push_back('{753, 11'd753, 10'd0, 8'b00_010_110});
      tbl.push_back('{754, 11'd754, 10'd0, 8'b00_110_110});
      tbl.push_back('{799, 11'd799, 10'd0, 8'b00_110_110});
      tbl.push_back('{800, 11'd0,   10'd1, 8'b10_110_111});
      tbl.push_back('{801, 11'd1,   10'd1, 8'b00_110_111});
      tbl.push_back('{802, 11'd2,   10'd1, 8'b00_111_111});

      // reset held 3 cycles, then released
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;

      foreach (tbl[k]) begin
         while (t < 64'(tbl[k].cyc)) step();
         check_val("tbl_hpos_d2", int'(f2_h), int'(tbl[k].h));
         check_val("tbl_vpos_d2", int'(f2_v), int'(tbl[k].v));
         check_val("tbl_hpos_d0", int'(f0_h), int'(tbl[k].h));
         check_val("tbl_flags", int'({f2_ls, f2_fs, f2_hs, f2_vs, f2_bl, f0_hs, f0_vs, f0_bl}),
                   int'(tbl[k].flags));
      end

      // line timing: h_sync low width/offset and visible width on line 0
      reset = 1'b1;
      step();
      reset = 1'b0;
      hs_cnt = 0; hs_first = -1; hs0_first = -1; bl_cnt = 0;
      for (int i = 0; i < 800; i++) begin
         if (i > 0) step();
         if (f2_hs == 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = i;
         end
         if (f0_hs == 1'b0 && hs0_first < 0) hs0_first = i;
         if (f0_bl == 1'b1) bl_cnt++;
      end
      check_val("hsync_low_len", hs_cnt, 96);
      check_val("hsync_first_d2", hs_first, 658);
      check_val("hsync_first_d0", hs0_first, 656);
      check_val("blank_line0_d0", bl_cnt, 640);

      // small frame: v_sync width/offset, one frame_start, visible pixel count
      reset = 1'b1;
      step();
      reset = 1'b0;
      vs_cnt = 0; vs_first = -1; fs_cnt = 0; sbl_cnt = 0;
      for (int i = 0; i < 170; i++) begin
         if (i > 0) step();
         if (s_vs == 1'b0) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = i;
         end
         if (s_fs == 1'b1) fs_cnt++;
         if (s_bl == 1'b1) sbl_cnt++;
      end
      check_val("s_vsync_low_len", vs_cnt, 34);
      check_val("s_vsync_first", vs_first, 122);
      check_val("s_frame_starts", fs_cnt, 1);
      check_val("s_visible_pixels", sbl_cnt, 60);

      // reset asserted inside v_sync (hpos=12, vpos=7 on the small DUT)
      reset = 1'b1;
      step();
      reset = 1'b0;
      while (t < 131) step();
      check_val("s_pre_rst_pos", int'({s_v, s_h}), int'({10'd7, 11'd12}));
      check_val("s_pre_rst_vs", int'(s_vs), 0);
      reset = 1'b1;
      step();
      check_val("s_rst_pos", int'({s_v, s_h}), 0);
      check_val("s_rst_sync", int'({s_hs, s_vs, s_bl}), int'(3'b110));
      reset = 1'b0;
      repeat (S_D + 2) begin
         step();
         check_val("s_post_rst_vs", int'(s_vs), 1);
      end

      // randomized run lengths and reset pulses
      for (int k = 0; k < 10; k++) begin
         repeat ($urandom_range(1500, 1)) step();
         reset = 1'b1;
         repeat ($urandom_range(3, 1)) step();
         reset = 1'b0;
      end

      // frame counter across 256+ small frames
      reset = 1'b1;
      step();
      reset = 1'b0;
      while (t < 43520) step();
`ifdef VGA_FRAME_COUNT_EN
      check_val("fc_before_wrap", int'(s_fc), 255);
`else
      check_val("fc_before_wrap", int'(s_fc), 0);
`endif
      step();
      check_val("fc_after_wrap", int'(s_fc), 0);
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
